// File: rtl/blkpang_feeder_pipe4_pkg.sv
// Shared types and constants for the pang feeder: lane geometry, FSM encoding,
// bank payload layout and a lane slice helper.
package blkpang_feeder_pipe4_pkg;

    localparam int unsigned LANES = 16;
    localparam int unsigned W     = 8;
    localparam int unsigned IDXW  = 4;
    localparam int unsigned BLKW  = LANES * W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    // One bank entry: block data plus its inclusive lane window.
    typedef struct packed {
        logic [BLKW-1:0] blk;
        logic [IDXW-1:0] start_idx;
        logic [IDXW-1:0] end_idx;
    } bank_t;

    // Byte lane k of a packed block (k=0 is the least significant byte).
    function automatic logic [W-1:0] lane(input logic [BLKW-1:0] blk, input logic [IDXW-1:0] k);
        return blk[W * 32'(k) +: W];
    endfunction

endpackage

// File: rtl/blkpang_feeder_pipe4_if.sv
// Upstream block handshake for the pang feeder.
//  in_valid/in_ready : transfer when both high
//  in_blk            : 16 byte lanes, lane k at [8k+7:8k]
//  in_start/in_end   : inclusive lane window to emit
interface blkpang_feeder_pipe4_if;
    import blkpang_feeder_pipe4_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [BLKW-1:0] in_blk;
    logic [IDXW-1:0] in_start;
    logic [IDXW-1:0] in_end;

    modport master (output in_valid, in_blk, in_start, in_end, input in_ready);
    modport slave  (input in_valid, in_blk, in_start, in_end, output in_ready);

endinterface

// File: rtl/blkpang_bank.sv
// One ping-pong bank: block/window register plus its full flag.
//  load       : capture d and mark full
//  clear      : mark empty (bank drained)
//  flush      : sync empty, overrides load/clear
//  q, full    : registered contents and flag
//  full_nxt_c : value full takes at the next edge
module blkpang_bank
    import blkpang_feeder_pipe4_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  logic  clear,
    input  logic  flush,
    input  bank_t d,
    output bank_t q,
    output logic  full,
    output logic  full_nxt_c
);

    // Next full flag; load and clear never target the same bank on one edge.
    always_comb begin
        full_nxt_c = full;
        if (flush) begin
            full_nxt_c = 1'b0;
        end else if (load) begin
            full_nxt_c = 1'b1;
        end else if (clear) begin
            full_nxt_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q    <= '0;
            full <= 1'b0;
        end else begin
            full <= full_nxt_c;
            if (load && !flush) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/blkpang_feeder_pipe4.sv
// Ping-pong feeder for the per-pang byte-select stage. Upstream fills one bank
// while the other drains its lane window one select per cycle.
//  clk, reset_n      : clock, async active-low reset
//  flush             : sync clear of banks, pointers and FSM
//  up                : upstream block handshake (slave side)
//  blk_o             : lanes of the draining bank
//  needfull          : a window is being drained
//  needpangstartinc  : start lane of the draining bank
//  needpangendinc    : end lane of the draining bank
//  next_sft          : lane select for this cycle
//  blk_done          : high on the last lane of a window
module blkpang_feeder_pipe4
    import blkpang_feeder_pipe4_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    blkpang_feeder_pipe4_if.slave up,
    output logic [BLKW-1:0]       blk_o,
    output logic                  needfull,
    output logic [IDXW-1:0]       needpangstartinc,
    output logic [IDXW-1:0]       needpangendinc,
    output logic [IDXW-1:0]       next_sft,
    output logic                  blk_done
);

    state_e          state, state_nxt;
    logic            wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    bank_t           bank_d, cur;
    bank_t           bank_q [2];
    logic [1:0]      full, full_nxt, load, clear;
    logic            transfer_c, reload_c, done_nxt, needfull_nxt, in_ready_nxt;
    logic [BLKW-1:0] blk_nxt;
    logic [IDXW-1:0] start_nxt, end_nxt, sft_nxt;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        blkpang_bank u_bank (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (load[g]),
            .clear      (clear[g]),
            .flush      (flush),
            .d          (bank_d),
            .q          (bank_q[g]),
            .full       (full[g]),
            .full_nxt_c (full_nxt[g])
        );
    end

    // Write side: accepted block goes to the bank under wr_ptr.
    always_comb begin
        transfer_c       = up.in_valid & up.in_ready & ~flush;
        bank_d.blk       = up.in_blk;
        bank_d.start_idx = up.in_start;
        bank_d.end_idx   = up.in_end;
        cur              = bank_q[rd_ptr];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. In the blk_done cycle rd_ptr already points at the other
    // bank, so a full one there starts straight away without a bubble.
    always_comb begin
        state_nxt = state;
        reload_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (full[rd_ptr]) begin
                    state_nxt = S_DRAIN;
                    reload_c  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (blk_done) begin
                    if (full[rd_ptr]) begin
                        reload_c = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            reload_c  = 1'b0;
        end
    end

    // Output next-values. The bank is released on the edge that presents its
    // last lane, so upstream sees in_ready during the blk_done cycle.
    always_comb begin
        blk_nxt   = blk_o;
        start_nxt = needpangstartinc;
        end_nxt   = needpangendinc;
        sft_nxt   = next_sft;
        if (reload_c) begin
            blk_nxt   = cur.blk;
            start_nxt = cur.start_idx;
            end_nxt   = cur.end_idx;
            sft_nxt   = cur.start_idx;
        end else if (state == S_DRAIN && state_nxt == S_DRAIN) begin
            sft_nxt = next_sft + IDXW'(1);
        end
        needfull_nxt = (state_nxt == S_DRAIN);
        done_nxt     = needfull_nxt && (sft_nxt == end_nxt);

        load          = '0;
        clear         = '0;
        load[wr_ptr]  = transfer_c;
        clear[rd_ptr] = done_nxt;

        wr_ptr_nxt   = flush ? 1'b0 : (wr_ptr ^ transfer_c);
        rd_ptr_nxt   = flush ? 1'b0 : (rd_ptr ^ done_nxt);
        in_ready_nxt = ~full_nxt[wr_ptr_nxt];
    end

    // Pointers and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            up.in_ready      <= 1'b1;
            blk_o            <= '0;
            needfull         <= 1'b0;
            needpangstartinc <= '0;
            needpangendinc   <= '0;
            next_sft         <= '0;
            blk_done         <= 1'b0;
        end else begin
            wr_ptr           <= wr_ptr_nxt;
            rd_ptr           <= rd_ptr_nxt;
            up.in_ready      <= in_ready_nxt;
            blk_o            <= blk_nxt;
            needfull         <= needfull_nxt;
            needpangstartinc <= start_nxt;
            needpangendinc   <= end_nxt;
            next_sft         <= sft_nxt;
            blk_done         <= done_nxt;
        end
    end

endmodule
